cache_ctrl_param: RTL and testbench
===================================

# cache_ctrl_param

Parametrised set-associative write-back cache controller: the next-generation tag/state engine between the CPU request port and the memory system. It holds tag, valid, dirty and true-LRU age state for `2**INDEX_W` sets × `WAYS` ways, and resolves each CPU request to a hit or a miss. Misses run an explicit valid/ack handshake to memory: write-back of a dirty victim, then line fill. A new whole-cache flush mode writes back every dirty line and invalidates the array. Data storage lives outside this block; the controller supplies only control, addresses and status.

## Interface
- `ADDR_W`, 24, byte address width.
- `OFFSET_W`, 6, line offset bits (64-byte lines).
- `INDEX_W`, 7, set index bits (128 sets).
- `WAYS`, 4, associativity; power of two, ≥2. `AGE_W = $clog2(WAYS)`. `TAG_W = ADDR_W-INDEX_W-OFFSET_W` (11 at defaults).
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `cpu_req_valid`  in  1  CPU request present.
- `cpu_req_write`  in  1  1 = write, 0 = read.
- `cpu_req_addr`  in  ADDR_W  request address.
- `cpu_req_ready`  out  1  controller can accept a request.
- `cpu_resp_valid`  out  1  one-cycle completion pulse.
- `cpu_resp_hit`  out  1  qualifies `cpu_resp_valid`: 1 = hit, 0 = miss serviced.
- `mem_req_valid`  out  1  memory request present.
- `mem_req_write`  out  1  1 = line write-back, 0 = line fill.
- `mem_req_addr`  out  ADDR_W  line address; offset bits are 0.
- `mem_ack`  in  1  memory accepts/completes the current request.
- `flush_req`  in  1  start a whole-cache flush; sampled only when idle.
- `flush_done`  out  1  one-cycle pulse when the flush completes.
- `evict`, `allocate`, `write_back`  out  1 each  status strobes (see Operation).

## Operation
- Address split: offset = `addr[OFFSET_W-1:0]`, index = `addr[OFFSET_W +: INDEX_W]`, tag = `addr[ADDR_W-1 -: TAG_W]`.
- Reset state: all valid and dirty bits 0; age of way w = w; FSM in IDLE; every output 0 except `cpu_req_ready` = 1.
- FSM states: IDLE, LOOKUP, WB, FILL, RESP, FL_SCAN, FL_WB.
- IDLE:
  - `cpu_req_ready` = 1.
  - If `flush_req` = 1: go to FL_SCAN with the line counter at 0. `flush_req` has priority; `cpu_req_ready` drops to 0 in that same cycle.
  - Else if `cpu_req_valid` = 1: latch addr and write into request registers, go to LOOKUP.
- LOOKUP (1 cycle):
  - Hit = a valid way whose tag equals the request tag.
  - On hit: pulse `cpu_resp_valid` with `cpu_resp_hit` = 1. Apply the LRU update to the hit way. Set its dirty bit if the request is a write. Go to IDLE.
  - On miss, choose the victim: the lowest-index invalid way if one exists, else the way with age `WAYS-1`. Latch the victim way, its tag and its valid bit.
  - Miss with a valid, dirty victim: go to WB. Otherwise: go to FILL.
- WB:
  - Drive `mem_req_valid` = 1, `mem_req_write` = 1, `mem_req_addr` = {victim tag, index, 0}.
  - `evict` = 1 and `write_back` = 1.
  - On `mem_ack`: clear the victim's dirty bit, go to FILL.
- FILL:
  - Drive `mem_req_valid` = 1, `mem_req_write` = 0, `mem_req_addr` = {req tag, index, 0}.
  - `allocate` = 1; `evict` = 1 if the latched victim was valid.
  - On `mem_ack`: write the victim's tag, set valid = 1, set dirty = request write bit, apply the LRU update to the victim. Go to RESP.
- RESP: pulse `cpu_resp_valid` with `cpu_resp_hit` = 0, go to IDLE.
- LRU update on way `a` whose old age is `x`: age[a] becomes 0; every way in the set with age < `x` increments by 1. Ages in a set always remain a permutation of 0..`WAYS-1`.
- FL_SCAN: examine one line per cycle, counter = {set, way}.
  - Valid and dirty line: go to FL_WB.
  - Otherwise: clear valid, advance the counter.
  - After the last line: pulse `flush_done`, reset all ages to way index, go to IDLE.
- FL_WB:
  - Write-back request for the line (`write_back` = 1, `evict` = 1).
  - On `mem_ack`: clear valid and dirty, advance the counter, return to FL_SCAN. If this was the last line, finish as in FL_SCAN.
- `mem_ack` is ignored while `mem_req_valid` = 0.
- `cpu_req_*` inputs are ignored outside IDLE.

## Timing
- A request is accepted on the edge where `cpu_req_valid` and `cpu_req_ready` are both 1 (call it cycle 0).
- Hit: `cpu_resp_valid` is high in cycle 1; the next request can be accepted in cycle 2.
- Clean miss: `mem_req_valid` rises in cycle 2 and holds, with address and write stable, up to and including the `mem_ack` cycle. `mem_ack` may arrive in the first request cycle. `cpu_resp_valid` is high the cycle after the fill `mem_ack`.
- Dirty miss: WB begins in cycle 2. FILL begins the cycle after the WB `mem_ack`.
- Flush of an all-clean cache takes exactly `2**INDEX_W * WAYS` FL_SCAN cycles. `flush_done` is high in the last of them.
- An asynchronous `rst` assertion during any state forces the reset state immediately. Any in-flight memory request is abandoned with `mem_req_valid` = 0.

## Test plan
- Read 0x000040 after reset → miss, FILL at 0x000040, `mem_ack` at cycle 4 → `cpu_resp_valid` with hit = 0 in cycle 5. Re-read 0x000040 → hit = 1 in cycle 1.
- Write-miss 0x000040, 0x002040, 0x004040, 0x006040, then read 0x008040 → WB of line 0x000040 (`write_back` = 1), then FILL of 0x008040; the replaced way was age 3.
- Hit 0x000040 after four fills of set 1, then miss 0x008040 → the victim is the oldest other way, not the re-touched 0x000040.
- Dirty line 0x00A080 present, pulse `flush_req` → exactly one write-back to 0x00A080, `flush_done` after 512 scan slots plus 1 WB, all lines invalid afterwards.
- `flush_req` and `cpu_req_valid` high together in IDLE → flush runs first; the request is accepted only after `flush_done`.
- `rst` low in FILL with `mem_req_valid` = 1 → all outputs 0 immediately (`cpu_req_ready` 1 after release). A subsequent read of the same address is a miss.

Source files
------------

// File: rtl/cache_ctrl_param.sv
// cache_ctrl_param: set-associative write-back cache tag/state engine
// with true-LRU replacement, memory handshake and whole-cache flush.
module cache_ctrl_param #(
  parameter int ADDR_W   = 24,
  parameter int OFFSET_W = 6,
  parameter int INDEX_W  = 7,
  parameter int WAYS     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_write,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  output logic              cpu_req_ready,
  output logic              cpu_resp_valid,
  output logic              cpu_resp_hit,
  output logic              mem_req_valid,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_ack,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              evict,
  output logic              allocate,
  output logic              write_back
);
  localparam int AGE_W  = $clog2(WAYS);
  localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int SETS   = 2**INDEX_W;
  localparam int CNT_W  = INDEX_W + AGE_W;
  localparam int LINE_W = ADDR_W - OFFSET_W;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB, FILL, RESP, FL_SCAN, FL_WB
  } state_e;

  state_e state_q, state_d;

  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [AGE_W-1:0] age_q   [SETS][WAYS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];

  logic [LINE_W-1:0] line_q;
  logic              req_wr_q;
  logic [AGE_W-1:0]  vic_q;
  logic [TAG_W-1:0]  vic_tag_q;
  logic              vic_val_q;
  logic [CNT_W-1:0]  fl_cnt_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   rtag;
  logic [INDEX_W-1:0] fl_set;
  logic [AGE_W-1:0]   fl_way;
  logic               fl_last;
  logic               fl_vd;

  assign idx     = line_q[INDEX_W-1:0];
  assign rtag    = line_q[LINE_W-1 -: TAG_W];
  assign fl_set  = fl_cnt_q[CNT_W-1 -: INDEX_W];
  assign fl_way  = fl_cnt_q[AGE_W-1:0];
  assign fl_last = &fl_cnt_q;
  assign fl_vd   = valid_q[fl_set][fl_way]
                 & dirty_q[fl_set][fl_way];

  logic unused_off;
  assign unused_off = ^cpu_req_addr[OFFSET_W-1:0];

  logic             hit;
  logic [AGE_W-1:0] hit_way;
  logic             inv_found;
  logic [AGE_W-1:0] inv_way;
  logic [AGE_W-1:0] old_way;
  logic [AGE_W-1:0] vic_way;
  logic             vic_valid;
  logic             vic_dirty;

  // Descending scan leaves the lowest matching way selected.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    old_way   = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[idx][w] == rtag) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (!valid_q[idx][w]) begin
        inv_found = 1'b1;
        inv_way   = AGE_W'(w);
      end
      if (age_q[idx][w] == AGE_W'(WAYS-1))
        old_way = AGE_W'(w);
    end
  end

  assign vic_way   = inv_found ? inv_way : old_way;
  assign vic_valid = valid_q[idx][vic_way];
  assign vic_dirty = dirty_q[idx][vic_way];

  always_comb begin
    state_d        = state_q;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_hit   = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_write  = 1'b0;
    mem_req_addr   = '0;
    flush_done     = 1'b0;
    evict          = 1'b0;
    allocate       = 1'b0;
    write_back     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cpu_req_ready = !flush_req;
        if (flush_req)
          state_d = FL_SCAN;
        else if (cpu_req_valid)
          state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          cpu_resp_valid = 1'b1;
          cpu_resp_hit   = 1'b1;
          state_d        = IDLE;
        end else if (vic_valid && vic_dirty) begin
          state_d = WB;
        end else begin
          state_d = FILL;
        end
      end
      WB: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {vic_tag_q, idx,
                         {OFFSET_W{1'b0}}};
        evict         = 1'b1;
        write_back    = 1'b1;
        if (mem_ack)
          state_d = FILL;
      end
      FILL: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {rtag, idx,
                         {OFFSET_W{1'b0}}};
        allocate      = 1'b1;
        evict         = vic_val_q;
        if (mem_ack)
          state_d = RESP;
      end
      RESP: begin
        cpu_resp_valid = 1'b1;
        state_d        = IDLE;
      end
      FL_SCAN: begin
        if (fl_vd) begin
          state_d = FL_WB;
        end else if (fl_last) begin
          flush_done = 1'b1;
          state_d    = IDLE;
        end
      end
      FL_WB: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {tag_q[fl_set][fl_way], fl_set,
                         {OFFSET_W{1'b0}}};
        evict         = 1'b1;
        write_back    = 1'b1;
        if (mem_ack) begin
          flush_done = fl_last;
          state_d    = fl_last ? IDLE : FL_SCAN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      line_q    <= '0;
      req_wr_q  <= 1'b0;
      vic_q     <= '0;
      vic_tag_q <= '0;
      vic_val_q <= 1'b0;
      fl_cnt_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          fl_cnt_q <= '0;
          if (!flush_req && cpu_req_valid) begin
            line_q   <= cpu_req_addr[ADDR_W-1:OFFSET_W];
            req_wr_q <= cpu_req_write;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (req_wr_q)
              dirty_q[idx][hit_way] <= 1'b1;
          end else begin
            vic_q     <= vic_way;
            vic_tag_q <= tag_q[idx][vic_way];
            vic_val_q <= vic_valid;
          end
        end
        WB: begin
          if (mem_ack)
            dirty_q[idx][vic_q] <= 1'b0;
        end
        FILL: begin
          if (mem_ack) begin
            valid_q[idx][vic_q] <= 1'b1;
            dirty_q[idx][vic_q] <= req_wr_q;
          end
        end
        FL_SCAN: begin
          if (!fl_vd) begin
            valid_q[fl_set][fl_way] <= 1'b0;
            fl_cnt_q <= fl_cnt_q + 1'b1;
          end
        end
        FL_WB: begin
          if (mem_ack) begin
            valid_q[fl_set][fl_way] <= 1'b0;
            dirty_q[fl_set][fl_way] <= 1'b0;
            fl_cnt_q <= fl_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tags are only meaningful under their valid bit, so no reset.
  always_ff @(posedge clk) begin
    if (state_q == FILL && mem_ack)
      tag_q[idx][vic_q] <= rtag;
  end

  logic             lru_en;
  logic [AGE_W-1:0] lru_way;
  logic [AGE_W-1:0] lru_x;

  assign lru_en  = (state_q == LOOKUP && hit)
                || (state_q == FILL && mem_ack);
  assign lru_way = (state_q == LOOKUP) ? hit_way : vic_q;
  assign lru_x   = age_q[idx][lru_way];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= AGE_W'(w);
    end else if (flush_done) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= AGE_W'(w);
    end else if (lru_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AGE_W'(w) == lru_way)
          age_q[idx][w] <= '0;
        else if (age_q[idx][w] < lru_x)
          age_q[idx][w] <= age_q[idx][w] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_ctrl_param.sv
// tb_cache_ctrl_param: scoreboard bench with a timestamp-LRU
// reference model and a randomized memory responder.
module tb_cache_ctrl_param;
  localparam int ADDR_W   = 24;
  localparam int OFFSET_W = 6;
  localparam int INDEX_W  = 7;
  localparam int WAYS     = 4;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int SETS     = 2**INDEX_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cpu_req_valid = 1'b0;
  logic              cpu_req_write = 1'b0;
  logic [ADDR_W-1:0] cpu_req_addr = '0;
  logic              cpu_req_ready;
  logic              cpu_resp_valid;
  logic              cpu_resp_hit;
  logic              mem_req_valid;
  logic              mem_req_write;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_ack = 1'b0;
  logic              flush_req = 1'b0;
  logic              flush_done;
  logic              evict;
  logic              allocate;
  logic              write_back;

  cache_ctrl_param #(
    .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W),
    .INDEX_W(INDEX_W), .WAYS(WAYS)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid),
    .cpu_req_write(cpu_req_write),
    .cpu_req_addr(cpu_req_addr),
    .cpu_req_ready(cpu_req_ready),
    .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_hit(cpu_resp_hit),
    .mem_req_valid(mem_req_valid),
    .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr),
    .mem_ack(mem_ack),
    .flush_req(flush_req),
    .flush_done(flush_done),
    .evict(evict),
    .allocate(allocate),
    .write_back(write_back)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_mis = 0;
  int  cyc = 0;
  int  acc_cyc = 0;
  int  resp_cyc = 0;
  int  fd_cyc = 0;
  int  fixed_delay = -1;
  int  lat;

  bit               m_v   [SETS][WAYS];
  bit               m_d   [SETS][WAYS];
  logic [TAG_W-1:0] m_t   [SETS][WAYS];
  int               m_use [SETS][WAYS];
  int               mtime = 0;

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
  endtask

  task automatic timeout(string name);
    n_cmp++;
    n_mis++;
    $display("FAIL %s: timed out waiting for DUT", name);
    summary();
    $finish;
  endtask

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_ev(
    bit wr, logic [ADDR_W-1:0] a, bit ev, bit al, bit wb);
    return {4'b0, wr, a, ev, al, wb};
  endfunction

  task automatic push(int k, logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic model_access(bit wr, logic [ADDR_W-1:0] a);
    int s;
    int hw;
    int vw;
    logic [TAG_W-1:0] t;
    s  = int'(a[OFFSET_W +: INDEX_W]);
    t  = a[ADDR_W-1 -: TAG_W];
    hw = -1;
    vw = -1;
    mtime++;
    for (int w = 0; w < WAYS; w++)
      if (m_v[s][w] && m_t[s][w] == t) hw = w;
    if (hw >= 0) begin
      push(0, 32'd1);
      m_use[s][hw] = mtime;
      if (wr) m_d[s][hw] = 1'b1;
    end else begin
      for (int w = WAYS-1; w >= 0; w--)
        if (!m_v[s][w]) vw = w;
      if (vw < 0) begin
        vw = 0;
        for (int w = 1; w < WAYS; w++)
          if (m_use[s][w] < m_use[s][vw]) vw = w;
      end
      if (m_v[s][vw] && m_d[s][vw])
        push(1, mem_ev(1'b1, {m_t[s][vw], INDEX_W'(s),
                       OFFSET_W'(0)}, 1'b1, 1'b0, 1'b1));
      push(1, mem_ev(1'b0, {t, INDEX_W'(s), OFFSET_W'(0)},
                     m_v[s][vw], 1'b1, 1'b0));
      push(0, 32'd0);
      m_v[s][vw]   = 1'b1;
      m_d[s][vw]   = wr;
      m_t[s][vw]   = t;
      m_use[s][vw] = mtime;
    end
  endtask

  task automatic model_flush();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        if (m_v[s][w] && m_d[s][w])
          push(1, mem_ev(1'b1, {m_t[s][w], INDEX_W'(s),
                         OFFSET_W'(0)}, 1'b1, 1'b0, 1'b1));
        m_v[s][w] = 1'b0;
        m_d[s][w] = 1'b0;
      end
    push(2, 32'd0);
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_v[s][w] = 1'b0;
        m_d[s][w] = 1'b0;
      end
  endtask

  function automatic logic [63:0] outs();
    return {31'b0, cpu_req_ready, cpu_resp_valid,
            cpu_resp_hit, mem_req_valid, mem_req_write,
            mem_req_addr, flush_done, evict, allocate,
            write_back};
  endfunction

  task automatic check_ev(int k, logic [31:0] d, string name);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_mis++;
      $display("FAIL %s: unexpected event kind %0d data %h",
               name, k, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.data !== d) begin
        n_mis++;
        $display("FAIL %s: got kind %0d data %h expected kind %0d data %h",
                 name, k, d, e.kind, e.data);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every DUT output event is popped against the model.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (cpu_resp_valid) begin
        resp_cyc = cyc;
        check_ev(0, {31'b0, cpu_resp_hit}, "resp");
      end
      if (mem_req_valid && mem_ack)
        check_ev(1, mem_ev(mem_req_write, mem_req_addr,
                 evict, allocate, write_back), "mem");
      if (flush_done) begin
        fd_cyc = cyc;
        check_ev(2, 32'd0, "flush_done");
      end
    end
  end

  function automatic int pick();
    if (fixed_delay >= 0) return fixed_delay;
    return int'($urandom_range(0, 3));
  endfunction

  // Memory responder; also throws stray acks while idle.
  initial begin
    int wcnt;
    bit pv;
    bit pa;
    wcnt = 0;
    pv = 1'b0;
    pa = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        mem_ack = 1'b0;
        pv = 1'b0;
        pa = 1'b0;
      end else begin
        if (mem_req_valid && (!pv || pa)) wcnt = pick();
        pv = mem_req_valid;
        if (mem_req_valid) begin
          if (wcnt == 0) mem_ack = 1'b1;
          else begin
            mem_ack = 1'b0;
            wcnt--;
          end
        end else begin
          mem_ack = ($urandom_range(0, 5) == 0);
        end
        pa = mem_ack && mem_req_valid;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 4000) timeout("wait_idle");
    end
  endtask

  task automatic accept(bit wr, logic [ADDR_W-1:0] a);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (cpu_req_ready) break;
      n++;
      if (n > 4000) timeout("accept");
    end
    acc_cyc = cyc;
    model_access(wr, a);
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    cpu_req_write = 1'($urandom);
    cpu_req_addr  = ADDR_W'($urandom);
  endtask

  task automatic do_req(bit wr, logic [ADDR_W-1:0] a);
    cpu_req_valid = 1'b1;
    cpu_req_write = wr;
    cpu_req_addr  = a;
    accept(wr, a);
    wait_idle();
  endtask

  task automatic do_flush(output int l);
    int c0;
    c0 = cyc;
    flush_req = 1'b1;
    model_flush();
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    wait_idle();
    l = fd_cyc - c0;
  endtask

  initial begin
    #1_000_000;
    timeout("watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] a;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", outs(), 64'h1_0000_0000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_idle", 64'(cpu_req_ready), 64'd1);

    fixed_delay = 2;
    do_req(1'b0, 24'h000040);
    chk("miss_lat", 64'(resp_cyc - acc_cyc), 64'd5);
    do_req(1'b0, 24'h000040);
    chk("hit_lat", 64'(resp_cyc - acc_cyc), 64'd1);
    fixed_delay = -1;

    do_req(1'b1, 24'h000040);
    do_req(1'b1, 24'h002040);
    do_req(1'b1, 24'h004040);
    do_req(1'b1, 24'h006040);
    do_req(1'b0, 24'h008040);

    do_flush(lat);
    do_req(1'b1, 24'h000040);
    do_req(1'b1, 24'h002040);
    do_req(1'b1, 24'h004040);
    do_req(1'b1, 24'h006040);
    do_req(1'b0, 24'h000040);
    do_req(1'b0, 24'h008040);

    do_flush(lat);
    do_req(1'b1, 24'h00A080);
    fixed_delay = 0;
    do_flush(lat);
    chk("flush_lat_1wb", 64'(lat), 64'd513);
    do_flush(lat);
    chk("flush_lat_clean", 64'(lat), 64'd512);
    fixed_delay = -1;
    do_req(1'b0, 24'h00A080);

    do_req(1'b1, 24'h00A080);
    flush_req     = 1'b1;
    cpu_req_valid = 1'b1;
    cpu_req_write = 1'b0;
    cpu_req_addr  = 24'h00A080;
    @(negedge clk);
    chk("ready_drop", 64'(cpu_req_ready), 64'd0);
    model_flush();
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    accept(1'b0, 24'h00A080);
    chk("req_after_flush", 64'(acc_cyc > fd_cyc), 64'd1);
    wait_idle();

    fixed_delay = 30;
    cpu_req_valid = 1'b1;
    cpu_req_write = 1'b0;
    cpu_req_addr  = 24'h123440;
    accept(1'b0, 24'h123440);
    n = 0;
    while (!mem_req_valid) begin
      @(negedge clk);
      n++;
      if (n > 100) timeout("fill_start");
    end
    #2;
    rst = 1'b0;
    #1;
    chk("rst_outs", outs() & 64'h0_FFFF_FFFF, 64'd0);
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(cpu_req_ready), 64'd1);
    fixed_delay = -1;
    @(posedge clk);
    #1;
    do_req(1'b0, 24'h123440);

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_flush(lat);
      end else begin
        a = {TAG_W'($urandom_range(0, 7)),
             INDEX_W'($urandom_range(0, 3)),
             OFFSET_W'($urandom)};
        do_req(1'($urandom), a);
      end
    end

    summary();
    $finish;
  end

endmodule
